control_register_file: RTL and testbench

Parametrised control-register file for the w80386dx core, holding CR0..CR(N-1) with per-register write masks, reserved-register handling and multiple combinational read ports. It captures page-fault linear addresses into CR2 from the paging unit and sequences TLB-invalidate handshakes on CR3 loads and on CR0.PG changes. It sits between the microcode execute stage (MOV CRn, CLTS) and the paging unit.

---
 rtl/cr_pkg.sv | 40 ++++
 rtl/tlb_flush_sequencer.sv | 63 ++++++
 rtl/control_register_file.sv | 87 ++++++++
 tb/tb_control_register_file.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cr_pkg.sv
// Shared constants, write-mask function and flush FSM encoding for the
// control-register file.
package cr_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 64;

  localparam int unsigned CR0_IDX = 0;
  localparam int unsigned CR2_IDX = 2;
  localparam int unsigned CR3_IDX = 3;

  localparam int unsigned PE_BIT = 0;
  localparam int unsigned MP_BIT = 1;
  localparam int unsigned EM_BIT = 2;
  localparam int unsigned TS_BIT = 3;
  localparam int unsigned R_BIT  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REQ1 = 2'd2
  } flush_state_t;

  // Storable bits of register idx. Slots not listed here are reserved and
  // read as zero. Callers keep the low `width` bits.
  function automatic logic [MAX_DATA_WIDTH-1:0] cr_write_mask(input int unsigned idx,
                                                              input int unsigned width);
    logic [MAX_DATA_WIDTH-1:0] m;
    m = '0;
    if (idx == CR0_IDX) begin
      for (int unsigned i = PE_BIT; i <= R_BIT; i++) m[i] = 1'b1;
      m[width-1] = 1'b1;
    end else if (idx == CR2_IDX) begin
      for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) if (i < width) m[i] = 1'b1;
    end else if (idx == CR3_IDX) begin
      for (int unsigned i = 12; i < MAX_DATA_WIDTH; i++) if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tlb_flush_sequencer.sv
// TLB-invalidate handshake sequencer with a single collapsing pending flag.
//
// state | meaning
// IDLE  | no flush in progress
// REQ   | tlb_flush_req asserted, waiting for ack
// REQ1  | one-cycle gap before re-issuing a pending flush
module tlb_flush_sequencer
  import cr_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic trigger,
  input  logic ack,
  output logic req,
  output logic busy
);

  flush_state_t state_q, state_d;
  logic         pending_q, pending_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    req       = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) state_d = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (ack) begin
          // A trigger landing with the ack is served by the next flush.
          if (pending_q || trigger) begin
            state_d   = REQ1;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (trigger) begin
          pending_d = 1'b1;
        end
      end
      REQ1: begin
        state_d = REQ;
        if (trigger) pending_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE) | pending_q;

endmodule

// File: rtl/control_register_file.sv
// CR0..CR(N-1) register file with per-register write masks, CR2 fault
// capture, CLTS and TLB-flush triggering on CR3 loads / CR0.PG changes.
module control_register_file
  import cr_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int REG_COUNT  = 8,
  parameter  int READ_PORTS = 2,
  localparam int IDX_WIDTH  = $clog2(REG_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [IDX_WIDTH-1:0]  write_index,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [IDX_WIDTH-1:0]  read_index [READ_PORTS],
  output logic [DATA_WIDTH-1:0] read_data  [READ_PORTS],
  input  logic                  clts,
  input  logic                  page_fault_valid,
  input  logic [DATA_WIDTH-1:0] page_fault_address,
  output logic                  tlb_flush_req,
  input  logic                  tlb_flush_ack,
  output logic                  busy,
  output logic                  PE,
  output logic                  MP,
  output logic                  EM,
  output logic                  TS,
  output logic                  R,
  output logic                  PG,
  output logic [DATA_WIDTH-13:0] page_directory_base
);

  // Indices past REG_COUNT get a slot with an all-zero mask, so they read 0.
  localparam int SLOTS = 1 << IDX_WIDTH;

  logic [DATA_WIDTH-1:0] cr_q    [SLOTS];
  logic [DATA_WIDTH-1:0] cr_d    [SLOTS];
  logic [DATA_WIDTH-1:0] wr_mask [SLOTS];
  logic                  flush_trigger;

  for (genvar g = 0; g < SLOTS; g++) begin : g_mask
    localparam logic [MAX_DATA_WIDTH-1:0] FULL_MASK = cr_write_mask(g, DATA_WIDTH);
    assign wr_mask[g] = FULL_MASK[DATA_WIDTH-1:0];
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) cr_d[i] = cr_q[i];
    if (write_enable) cr_d[write_index] = write_data & wr_mask[write_index];
    if (clts) cr_d[CR0_IDX][TS_BIT] = 1'b0;
    if (page_fault_valid) cr_d[CR2_IDX] = page_fault_address;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) cr_q[i] <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) cr_q[i] <= cr_d[i];
    end
  end

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) read_data[p] = cr_q[read_index[p]];
  end

  assign flush_trigger = write_enable &&
                         ((write_index == IDX_WIDTH'(CR3_IDX)) ||
                          ((write_index == IDX_WIDTH'(CR0_IDX)) &&
                           (write_data[DATA_WIDTH-1] != cr_q[CR0_IDX][DATA_WIDTH-1])));

  tlb_flush_sequencer u_flush (
    .clock   (clock),
    .reset   (reset),
    .trigger (flush_trigger),
    .ack     (tlb_flush_ack),
    .req     (tlb_flush_req),
    .busy    (busy)
  );

  assign PE = cr_q[CR0_IDX][PE_BIT];
  assign MP = cr_q[CR0_IDX][MP_BIT];
  assign EM = cr_q[CR0_IDX][EM_BIT];
  assign TS = cr_q[CR0_IDX][TS_BIT];
  assign R  = cr_q[CR0_IDX][R_BIT];
  assign PG = cr_q[CR0_IDX][DATA_WIDTH-1];
  assign page_directory_base = cr_q[CR3_IDX][DATA_WIDTH-1:12];

endmodule

// File: tb/tb_control_register_file.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the control registers.
module tb_control_register_file;

  localparam int DW = 32;
  localparam int RC = 8;
  localparam int RP = 2;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          write_enable;
  logic [IW-1:0] write_index;
  logic [DW-1:0] write_data;
  logic [IW-1:0] read_index [RP];
  logic [DW-1:0] read_data  [RP];
  logic          clts;
  logic          page_fault_valid;
  logic [DW-1:0] page_fault_address;
  logic          tlb_flush_req;
  logic          tlb_flush_ack;
  logic          busy;
  logic          PE, MP, EM, TS, R, PG;
  logic [DW-13:0] page_directory_base;

  control_register_file #(.DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP)) dut (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_index(write_index), .write_data(write_data),
    .read_index(read_index), .read_data(read_data),
    .clts(clts), .page_fault_valid(page_fault_valid), .page_fault_address(page_fault_address),
    .tlb_flush_req(tlb_flush_req), .tlb_flush_ack(tlb_flush_ack), .busy(busy),
    .PE(PE), .MP(MP), .EM(EM), .TS(TS), .R(R), .PG(PG),
    .page_directory_base(page_directory_base)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] m_cr [RC];
  bit last_trig;

  task automatic check_value(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] keep_bits(input int idx);
    case (idx)
      0:       return 32'h8000_001F;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'hFFFF_F000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic clear_inputs();
    write_enable = 0; write_index = '0; write_data = '0;
    clts = 0; page_fault_valid = 0; page_fault_address = '0; tlb_flush_ack = 0;
  endtask

  // One clock with the current inputs; the model advances alongside.
  task automatic step();
    logic [DW-1:0] nxt [RC];
    nxt = m_cr;
    last_trig = write_enable && (write_index == 3 ||
                (write_index == 0 && write_data[31] != m_cr[0][31]));
    if (write_enable) nxt[write_index] = write_data & keep_bits(int'(write_index));
    if (clts) nxt[0][3] = 1'b0;
    if (page_fault_valid) nxt[2] = page_fault_address;
    @(posedge clock);
    #1;
    m_cr = nxt;
  endtask

  task automatic write_cr(input int idx, input logic [DW-1:0] data);
    write_enable = 1; write_index = IW'(idx); write_data = data;
    step();
    write_enable = 0;
  endtask

  task automatic read_cr(input int idx, output logic [DW-1:0] val);
    read_index[0] = IW'(idx);
    #1;
    val = read_data[0];
  endtask

  task automatic check_model();
    int a, b;
    a = $urandom_range(0, RC-1);
    b = $urandom_range(0, RC-1);
    read_index[0] = IW'(a);
    read_index[1] = IW'(b);
    #1;
    check_value("rand_rd0", read_data[0], m_cr[a]);
    check_value("rand_rd1", read_data[1], m_cr[b]);
    check_value("rand_cr0_bits", {PG, 26'b0, R, TS, EM, MP, PE}, m_cr[0] & 32'h8000_001F);
    check_value("rand_pdb", 32'(page_directory_base), m_cr[3] >> 12);
  endtask

  initial begin
    logic [DW-1:0] v;
    int guard;
    clear_inputs();
    read_index[0] = '0; read_index[1] = '0;
    for (int i = 0; i < RC; i++) m_cr[i] = '0;
    reset = 1;
    #12;
    check_value("reset_req", tlb_flush_req, 0);
    check_value("reset_busy", busy, 0);
    check_value("reset_rd0", read_data[0], 0);
    @(negedge clock);
    reset = 0;

    // masked writes
    write_cr(0, 32'hFFFF_FFFF);
    read_cr(0, v);
    check_value("cr0_masked", v, 32'h8000_001F);
    check_value("cr0_flush_req", tlb_flush_req, 1);
    tlb_flush_ack = 1; step(); tlb_flush_ack = 0;
    check_value("cr0_flush_done", busy, 0);
    write_cr(3, 32'h1234_5FFF);
    check_value("cr3_pdb", 32'(page_directory_base), 32'h12345);
    read_cr(3, v);
    check_value("cr3_masked", v, 32'h1234_5000);
    check_value("cr3_flush_req", tlb_flush_req, 1);
    tlb_flush_ack = 1; step(); tlb_flush_ack = 0;
    write_cr(1, 32'hDEAD_BEEF);
    read_cr(1, v);
    check_value("cr1_reserved", v, 0);
    check_value("cr1_no_flush", busy, 0);
    tlb_flush_ack = 1; step(); tlb_flush_ack = 0;
    check_value("idle_ack_ignored", {busy, tlb_flush_req}, 0);

    // page fault beats CR2 write
    page_fault_valid = 1; page_fault_address = 32'h0040_1000;
    write_cr(2, 32'h1111_1111);
    page_fault_valid = 0;
    read_cr(2, v);
    check_value("pf_beats_write", v, 32'h0040_1000);

    // CLTS beats CR0 write (first write clears PG, so it flushes)
    write_cr(0, 32'h0000_0008);
    read_cr(0, v);
    check_value("cr0_ts_set", v, 32'h8);
    tlb_flush_ack = 1; step(); tlb_flush_ack = 0;
    clts = 1;
    write_cr(0, 32'h0000_0009);
    clts = 0;
    read_cr(0, v);
    check_value("clts_beats_write", v, 32'h1);
    check_value("clts_no_flush", busy, 0);

    // handshake with delayed ack
    write_cr(3, 32'hABCD_E000);
    check_value("hs_req_rise", tlb_flush_req, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("hs_req_hold", tlb_flush_req, 1);
    end
    tlb_flush_ack = 1; step(); tlb_flush_ack = 0;
    check_value("hs_req_drop", tlb_flush_req, 0);
    check_value("hs_busy_drop", busy, 0);

    // collapsed pending
    write_cr(3, 32'h0000_1000);
    check_value("cp_req", tlb_flush_req, 1);
    for (int i = 0; i < 3; i++) write_cr(3, 32'h0000_2000 + DW'(i) * 32'h1000);
    check_value("cp_busy", busy, 1);
    tlb_flush_ack = 1; step(); tlb_flush_ack = 0;
    check_value("cp_gap_req", tlb_flush_req, 0);
    check_value("cp_gap_busy", busy, 1);
    step();
    check_value("cp_second_req", tlb_flush_req, 1);
    step();
    check_value("cp_second_hold", tlb_flush_req, 1);
    tlb_flush_ack = 1; step(); tlb_flush_ack = 0;
    check_value("cp_done_busy", busy, 0);
    step(); step();
    check_value("cp_no_third", {busy, tlb_flush_req}, 0);

    // reset mid-flush
    write_cr(0, 32'h8000_0000);
    check_value("rm_req", tlb_flush_req, 1);
    check_value("rm_pg", PG, 1);
    #1 reset = 1;
    read_index[0] = 3'd0; read_index[1] = 3'd3;
    #1;
    check_value("rm_req_clr", tlb_flush_req, 0);
    check_value("rm_busy_clr", busy, 0);
    check_value("rm_pg_clr", PG, 0);
    check_value("rm_rd0", read_data[0], 0);
    check_value("rm_rd1", read_data[1], 0);
    for (int i = 0; i < RC; i++) m_cr[i] = '0;
    @(negedge clock);
    reset = 0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      write_enable = ($urandom_range(0, 2) == 0);
      write_index = IW'($urandom_range(0, RC-1));
      write_data = $urandom;
      clts = ($urandom_range(0, 7) == 0);
      page_fault_valid = ($urandom_range(0, 7) == 0);
      page_fault_address = $urandom;
      tlb_flush_ack = ($urandom_range(0, 2) == 0);
      step();
      check_model();
      if (last_trig) check_value("rand_busy_after_trig", busy, 1);
      if (!busy) check_value("rand_req_idle", tlb_flush_req, 0);
    end

    clear_inputs();
    tlb_flush_ack = 1;
    guard = 0;
    while (busy && guard < 20) begin
      step();
      guard++;
    end
    check_value("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
